// File: rtl/mc_lsu.sv
// mc_lsu: load/store unit between the multi-cycle CPU datapath and a
// word-wide, little-endian data memory that samples on the falling edge.
// Sub-word stores are performed as read-modify-write (RD then WR).
`timescale 1ns/1ps

module mc_lsu #(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic        mem_rw,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t      state_reg;
   state_t      state_next;

   // Request attributes captured in IDLE and used by the later states.
   logic        we_reg;
   logic [1:0]  size_reg;
   logic        sign_reg;
   logic [1:0]  lane_reg;
   logic [15:0] wdata_reg;
   logic        err_reg;
   logic [31:0] rdata_reg;
   logic [31:0] mem_addr_reg;
   logic [31:0] mem_wdata_reg;

   // Request classification, evaluated on the live inputs while IDLE.
   logic        size_illegal;
   logic        misaligned;
   logic        out_of_range;
   logic        reject;
   logic        word_store;
   logic [32:0] last_byte;

   assign last_byte    = {1'b0, addr[31:2], 2'b00} + 33'd3;
   assign size_illegal = (size == 2'b11);
   assign misaligned   = ((size == SZ_HALF) && addr[0]) ||
                         ((size == SZ_WORD) && (addr[1:0] != 2'b00));
   assign out_of_range = (last_byte >= 33'(MEM_BYTES));
   assign reject       = size_illegal || misaligned || out_of_range;
   assign word_store   = we && (size == SZ_WORD);

   // Read-modify-write merge: each byte lane either keeps the memory byte
   // or takes the matching byte of the store data.
   logic [31:0] merged_word;
   logic [3:0]  lane_hit;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         localparam int HALF_BYTE = gi % 2;
         localparam int HALF_SEL  = gi / 2;

         assign lane_hit[gi] = (size_reg == SZ_BYTE) ? (lane_reg == 2'(gi))
                                                     : (lane_reg[1] == 1'(HALF_SEL));

         assign merged_word[8*gi +: 8] =
            !lane_hit[gi]          ? mem_rdata[8*gi +: 8] :
            (size_reg == SZ_BYTE)  ? wdata_reg[7:0]       :
                                     wdata_reg[8*HALF_BYTE +: 8];
      end
   endgenerate

   // Load lane extraction and sign/zero extension.
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_value;

   // Select the addressed byte and halfword out of the memory word.
   always_comb begin
      byte_lane = mem_rdata[7:0];
      case (lane_reg)
         2'd0:    byte_lane = mem_rdata[7:0];
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   // Extend the selected lane to 32 bits according to size and signedness.
   always_comb begin
      load_value = mem_rdata;
      case (size_reg)
         SZ_BYTE: load_value = {{24{sign_reg & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_value = {{16{sign_reg & half_lane[15]}}, half_lane};
         default: load_value = mem_rdata;
      endcase
   end

   // State register; asynchronous reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (req) begin
               if (reject) begin
                  state_next = DONE;
               end else if (word_store) begin
                  state_next = WR;
               end else begin
                  state_next = RD;
               end
            end
         end
         RD:      state_next = we_reg ? WR : DONE;
         WR:      state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state; mem_rw is high only while in WR.
   always_comb begin
      busy   = (state_reg != IDLE);
      mem_rw = (state_reg == WR);
      done   = (state_reg == DONE);
      err    = (state_reg == DONE) && err_reg;
   end

   // Datapath registers: capture the request, the load result and the
   // write word; these only change on rising edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_reg        <= 1'b0;
         size_reg      <= 2'b00;
         sign_reg      <= 1'b0;
         lane_reg      <= 2'b00;
         wdata_reg     <= 16'h0;
         err_reg       <= 1'b0;
         rdata_reg     <= 32'h0;
         mem_addr_reg  <= 32'h0;
         mem_wdata_reg <= 32'h0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (req) begin
                  we_reg       <= we;
                  size_reg     <= size;
                  sign_reg     <= sign_ext;
                  lane_reg     <= addr[1:0];
                  wdata_reg    <= wdata[15:0];
                  err_reg      <= reject;
                  mem_addr_reg <= {addr[31:2], 2'b00};
                  if (!reject && word_store) begin
                     mem_wdata_reg <= wdata;
                  end
               end
            end
            RD: begin
               if (we_reg) begin
                  mem_wdata_reg <= merged_word;
               end else begin
                  rdata_reg <= load_value;
               end
            end
            WR: begin
               // Address and write word held stable for the whole cycle.
            end
            DONE: begin
               err_reg <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign rdata     = rdata_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule
